// File: rtl/npu_host_pkg.sv
// Shared definitions for the NPU host-port master: command opcodes, address map,
// FSM state encodings and the host address helper.
package npu_host_pkg;

  typedef enum logic [1:0] {
    OP_WRITE_BLK = 2'd0,
    OP_CTRL      = 2'd1,
    OP_READ      = 2'd2,
    OP_POLL      = 2'd3
  } host_op_e;

  localparam logic [2:0] SEL_CONV1  = 3'b001;
  localparam logic [2:0] SEL_CONV2  = 3'b010;
  localparam logic [2:0] SEL_FC1    = 3'b011;
  localparam logic [2:0] SEL_FC2    = 3'b100;
  localparam logic [2:0] SEL_CTRL   = 3'b101;
  localparam logic [2:0] SEL_IMAGE  = 3'b110;
  localparam logic [2:0] SEL_STATUS = 3'b111;

  localparam logic [11:0] CTRL_IDX_START    = 12'd2;
  localparam logic [11:0] CTRL_IDX_FC1_NEXT = 12'd3;
  localparam logic [11:0] STATUS_IDX        = 12'd0;
  localparam logic [11:0] RESULT_IDX        = 12'd1;

  localparam int STATUS_DONE_BIT            = 0;
  localparam int STATUS_FC1_GROUP_VALID_BIT = 1;

  localparam logic [2:0] ST_IDLE     = 3'd0;
  localparam logic [2:0] ST_PACK     = 3'd1;
  localparam logic [2:0] ST_WR       = 3'd2;
  localparam logic [2:0] ST_CTRL     = 3'd3;
  localparam logic [2:0] ST_RD_ISSUE = 3'd4;
  localparam logic [2:0] ST_RD_WAIT  = 3'd5;
  localparam logic [2:0] ST_RESP     = 3'd6;

  function automatic logic [15:0] host_addr(input logic [2:0] sel, input logic [11:0] idx);
    return {1'b0, sel, idx};
  endfunction

endpackage

// File: rtl/npu_byte_packer.sv
// Byte-to-word packer: little-endian, flushes early on the last byte with zero padding.
// The completed word is presented combinationally in the cycle its final byte is taken.
module npu_byte_packer (
  input  logic        clk,
  input  logic        rst,
  input  logic        en_i,
  input  logic        in_valid_i,
  input  logic [7:0]  in_data_i,
  input  logic        in_last_i,
  output logic        in_ready_o,
  output logic        word_valid_o,
  output logic [31:0] word_o
);

  logic [1:0]  cnt_q, cnt_d;
  logic [31:0] word_q, word_d;
  logic        take;

  assign in_ready_o = en_i;
  assign take       = en_i & in_valid_i;

  // Unfilled upper bytes of word_q are always zero, so OR-ing in the new byte pads for free.
  always_comb begin
    word_o       = word_q | ({24'h0, in_data_i} << {cnt_q, 3'b000});
    word_valid_o = take & ((cnt_q == 2'd3) | in_last_i);
    cnt_d        = cnt_q;
    word_d       = word_q;
    if (word_valid_o) begin
      cnt_d  = 2'd0;
      word_d = 32'h0;
    end else if (take) begin
      cnt_d  = cnt_q + 2'd1;
      word_d = word_o;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q  <= 2'd0;
      word_q <= 32'h0;
    end else begin
      cnt_q  <= cnt_d;
      word_q <= word_d;
    end
  end

endmodule

// File: rtl/npu_host_master.sv
// Host-side initiator for the NPU block-RAM host port: block writes, control pulses,
// single reads and status polling, each answered by a one-cycle response.
module npu_host_master
  import npu_host_pkg::*;
#(
  parameter int READ_LAT     = 1,
  parameter int POLL_TIMEOUT = 4096,
  parameter int LEN_W        = 12
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic [2:0]       cmd_sel,
  input  logic [11:0]      cmd_idx,
  input  logic [LEN_W-1:0] cmd_len,
  input  logic [31:0]      cmd_mask,
  input  logic             s_valid,
  output logic             s_ready,
  input  logic [7:0]       s_data,
  output logic             ena,
  output logic             wea,
  output logic [15:0]      addra,
  output logic [31:0]      dina,
  input  logic [31:0]      douta,
  output logic             rsp_valid,
  output logic [31:0]      rsp_data,
  output logic             rsp_err,
  output logic             busy
);

  localparam int LAT_W  = (READ_LAT > 1) ? $clog2(READ_LAT) : 1;
  localparam int POLL_W = (POLL_TIMEOUT > 1) ? $clog2(POLL_TIMEOUT) : 1;
  localparam logic [LAT_W-1:0]  LAT_LAST  = LAT_W'(READ_LAT - 1);
  localparam logic [POLL_W-1:0] POLL_LAST = POLL_W'(POLL_TIMEOUT - 1);

  logic [2:0]        state_q, state_d;
  host_op_e          op_q, op_d;
  logic [2:0]        sel_q, sel_d;
  logic [11:0]       idx_q, idx_d;
  logic [LEN_W-1:0]  rem_q, rem_d;
  logic [31:0]       mask_q, mask_d;
  logic [LAT_W-1:0]  lat_q, lat_d;
  logic [POLL_W-1:0] poll_q, poll_d;
  logic [31:0]       rsp_data_q, rsp_data_d;
  logic              rsp_err_q, rsp_err_d;
  logic              ena_q, ena_d, wea_q, wea_d;
  logic [15:0]       addra_q, addra_d;
  logic [31:0]       dina_q, dina_d;

  logic              word_valid;
  logic [31:0]       pack_word;
  logic              byte_take;

  npu_byte_packer u_packer (
    .clk          (clk),
    .rst          (rst),
    .en_i         (state_q == ST_PACK),
    .in_valid_i   (s_valid),
    .in_data_i    (s_data),
    .in_last_i    (rem_q == LEN_W'(1)),
    .in_ready_o   (s_ready),
    .word_valid_o (word_valid),
    .word_o       (pack_word)
  );

  assign byte_take = s_valid & s_ready;

  // Gated with rst so every output reads 0 while reset is held.
  assign cmd_ready = (state_q == ST_IDLE) & ~rst;
  assign busy      = (state_q != ST_IDLE);
  assign rsp_valid = (state_q == ST_RESP);
  assign rsp_data  = rsp_data_q;
  assign rsp_err   = rsp_err_q;
  assign ena       = ena_q;
  assign wea       = wea_q;
  assign addra     = addra_q;
  assign dina      = dina_q;

  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    sel_d      = sel_q;
    idx_d      = idx_q;
    rem_d      = rem_q;
    mask_d     = mask_q;
    lat_d      = lat_q;
    poll_d     = poll_q;
    rsp_data_d = rsp_data_q;
    rsp_err_d  = rsp_err_q;
    ena_d      = 1'b0;
    wea_d      = 1'b0;
    addra_d    = addra_q;
    dina_d     = dina_q;
    case (state_q)
      ST_IDLE: begin
        if (cmd_valid) begin
          op_d       = host_op_e'(cmd_op);
          sel_d      = cmd_sel;
          idx_d      = cmd_idx;
          rem_d      = cmd_len;
          mask_d     = cmd_mask;
          poll_d     = '0;
          rsp_data_d = 32'h0;
          rsp_err_d  = 1'b0;
          case (host_op_e'(cmd_op))
            OP_WRITE_BLK: state_d = (cmd_len == '0) ? ST_RESP : ST_PACK;
            OP_CTRL: begin
              state_d = ST_CTRL;
              ena_d   = 1'b1;
              wea_d   = 1'b1;
              addra_d = host_addr(cmd_sel, cmd_idx);
              dina_d  = 32'h1;
            end
            default: begin
              state_d = ST_RD_ISSUE;
              ena_d   = 1'b1;
              addra_d = host_addr(cmd_sel, cmd_idx);
            end
          endcase
        end
      end
      ST_PACK: begin
        if (byte_take) rem_d = rem_q - 1'b1;
        if (word_valid) begin
          state_d = ST_WR;
          ena_d   = 1'b1;
          wea_d   = 1'b1;
          addra_d = host_addr(sel_q, idx_q);
          dina_d  = pack_word;
        end
      end
      ST_WR: begin
        idx_d   = idx_q + 12'd1;
        state_d = (rem_q == '0) ? ST_RESP : ST_PACK;
      end
      ST_CTRL: state_d = ST_RESP;
      ST_RD_ISSUE: begin
        lat_d   = '0;
        state_d = ST_RD_WAIT;
      end
      ST_RD_WAIT: begin
        if (lat_q == LAT_LAST) begin
          rsp_data_d = douta;
          if (op_q == OP_READ || (douta & mask_q) == mask_q) begin
            state_d = ST_RESP;
          end else if (poll_q == POLL_LAST) begin
            state_d   = ST_RESP;
            rsp_err_d = 1'b1;
          end else begin
            // Retry immediately; addra still holds the status address.
            poll_d  = poll_q + 1'b1;
            state_d = ST_RD_ISSUE;
            ena_d   = 1'b1;
          end
        end else begin
          lat_d = lat_q + 1'b1;
        end
      end
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      op_q       <= OP_WRITE_BLK;
      sel_q      <= 3'd0;
      idx_q      <= 12'd0;
      rem_q      <= '0;
      mask_q     <= 32'h0;
      lat_q      <= '0;
      poll_q     <= '0;
      rsp_data_q <= 32'h0;
      rsp_err_q  <= 1'b0;
      ena_q      <= 1'b0;
      wea_q      <= 1'b0;
      addra_q    <= 16'h0;
      dina_q     <= 32'h0;
    end else begin
      state_q    <= state_d;
      op_q       <= op_d;
      sel_q      <= sel_d;
      idx_q      <= idx_d;
      rem_q      <= rem_d;
      mask_q     <= mask_d;
      lat_q      <= lat_d;
      poll_q     <= poll_d;
      rsp_data_q <= rsp_data_d;
      rsp_err_q  <= rsp_err_d;
      ena_q      <= ena_d;
      wea_q      <= wea_d;
      addra_q    <= addra_d;
      dina_q     <= dina_d;
    end
  end

endmodule

// File: tb/tb_npu_host_master.sv
// Self-checking bench for npu_host_master: transaction-level model of expected port
// accesses and responses, checked on every falling edge, plus directed literal checks.
module tb_npu_host_master;
  import npu_host_pkg::*;

  localparam int TO = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        cmd_valid, cmd_ready;
  logic [1:0]  cmd_op;
  logic [2:0]  cmd_sel;
  logic [11:0] cmd_idx, cmd_len;
  logic [31:0] cmd_mask;
  logic        s_valid, s_ready;
  logic [7:0]  s_data;
  logic        ena, wea, rsp_valid, rsp_err, busy;
  logic [15:0] addra;
  logic [31:0] dina, douta, rsp_data;

  logic        cmd_valid2, cmd_ready2, s_ready2;
  logic        ena2, wea2, rsp_valid2, rsp_err2, busy2;
  logic [15:0] addra2;
  logic [31:0] dina2, douta2, rsp_data2, d2_pipe;

  npu_host_master #(.READ_LAT(1), .POLL_TIMEOUT(TO), .LEN_W(12)) dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_sel(cmd_sel), .cmd_idx(cmd_idx), .cmd_len(cmd_len), .cmd_mask(cmd_mask),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data), .ena(ena), .wea(wea),
    .addra(addra), .dina(dina), .douta(douta), .rsp_valid(rsp_valid), .rsp_data(rsp_data),
    .rsp_err(rsp_err), .busy(busy)
  );

  npu_host_master #(.READ_LAT(2), .POLL_TIMEOUT(TO), .LEN_W(12)) dut2 (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid2), .cmd_ready(cmd_ready2), .cmd_op(OP_READ),
    .cmd_sel(SEL_STATUS), .cmd_idx(RESULT_IDX), .cmd_len(12'd0), .cmd_mask(32'h0),
    .s_valid(1'b0), .s_ready(s_ready2), .s_data(8'h0), .ena(ena2), .wea(wea2),
    .addra(addra2), .dina(dina2), .douta(douta2), .rsp_valid(rsp_valid2), .rsp_data(rsp_data2),
    .rsp_err(rsp_err2), .busy(busy2)
  );

  typedef struct packed {
    logic        wea;
    logic [15:0] addr;
    logic [31:0] data;
  } acc_t;

  acc_t        exp_acc_q[$];
  logic [32:0] exp_rsp_q[$];
  logic [31:0] rd_q[$];

  int errors = 0;
  int checks = 0;
  int n_wr = 0, n_rd = 0, n_rsp = 0, n_rd2 = 0;
  int wr_in_cmd = 0;
  logic [31:0] first_wd, last_wd, last_rsp_data;
  logic [15:0] first_wa, last_wa;
  logic        last_rsp_err;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic fail(input string name, input logic [31:0] act);
    checks++;
    errors++;
    $display("FAIL %s: observed %h, expected none", name, act);
  endtask

  // Port memory: read data appears READ_LAT cycles after the issue cycle, junk otherwise.
  always @(posedge clk) begin
    if (ena && !wea && rd_q.size() > 0) douta <= rd_q.pop_front();
    else douta <= 32'hDEADBEEF;
    if (ena2 && !wea2) d2_pipe <= 32'hFFFFF3A1;
    else d2_pipe <= 32'hDEADBEEF;
    douta2 <= d2_pipe;
  end

  always @(negedge clk) begin
    if (!rst) begin
      if (ena2 && !wea2) n_rd2++;
      if (ena) begin
        if (wea) begin
          n_wr++;
          if (wr_in_cmd == 0) begin
            first_wd = dina;
            first_wa = addra;
          end
          wr_in_cmd++;
          last_wd = dina;
          last_wa = addra;
        end else begin
          n_rd++;
        end
        if (exp_acc_q.size() == 0) begin
          fail("unexpected_access", {16'h0, addra});
        end else begin
          acc_t e;
          e = exp_acc_q.pop_front();
          chk("acc_wea", {31'h0, wea}, {31'h0, e.wea});
          chk("acc_addr", {16'h0, addra}, {16'h0, e.addr});
          if (e.wea) chk("acc_data", dina, e.data);
        end
      end
      if (rsp_valid) begin
        n_rsp++;
        last_rsp_data = rsp_data;
        last_rsp_err  = rsp_err;
        if (exp_rsp_q.size() == 0) begin
          fail("unexpected_rsp", rsp_data);
        end else begin
          logic [32:0] r;
          r = exp_rsp_q.pop_front();
          chk("rsp_data", rsp_data, r[31:0]);
          chk("rsp_err", {31'h0, rsp_err}, {31'h0, r[32]});
        end
      end
    end
  end

  // Model: a block write becomes ceil(len/4) little-endian words at consecutive wrapping indices.
  task automatic model_write(input logic [2:0] sel, input logic [11:0] idx, input int len,
                             input int base);
    int nw;
    nw = (len + 3) / 4;
    for (int w = 0; w < nw; w++) begin
      acc_t a;
      logic [31:0] word;
      logic [7:0] bv;
      word = 32'h0;
      for (int k = 0; k < 4; k++) begin
        if (4 * w + k < len) begin
          bv = 8'(base + 4 * w + k);
          word = word | ({24'h0, bv} << (8 * k));
        end
      end
      a.wea  = 1'b1;
      a.addr = {1'b0, sel, 12'((int'(idx) + w) % 4096)};
      a.data = word;
      exp_acc_q.push_back(a);
    end
    exp_rsp_q.push_back({1'b0, 32'h0});
  endtask

  // Model: reads continue until the mask is satisfied or TO attempts have failed.
  task automatic model_poll(input logic [2:0] sel, input logic [11:0] idx, input logic [31:0] mask,
                            input logic single, output int nreads);
    logic [31:0] v;
    acc_t a;
    v = 32'h0;
    nreads = 0;
    for (int i = 0; i < TO; i++) begin
      v = (i < rd_q.size()) ? rd_q[i] : 32'hDEADBEEF;
      a.wea  = 1'b0;
      a.addr = {1'b0, sel, idx};
      a.data = 32'h0;
      exp_acc_q.push_back(a);
      nreads = i + 1;
      if (single || (v & mask) == mask) begin
        exp_rsp_q.push_back({1'b0, v});
        return;
      end
    end
    exp_rsp_q.push_back({1'b1, v});
  endtask

  task automatic issue(input logic [1:0] op, input logic [2:0] sel, input logic [11:0] idx,
                       input int len, input logic [31:0] mask);
    int b;
    @(negedge clk);
    cmd_op = op; cmd_sel = sel; cmd_idx = idx; cmd_len = 12'(len); cmd_mask = mask;
    cmd_valid = 1'b1;
    wr_in_cmd = 0;
    b = 0;
    while (!cmd_ready && b < 50) begin
      @(negedge clk);
      b++;
    end
    if (!cmd_ready) fail("cmd_accept_timeout", 32'h0);
    @(posedge clk);
    #1 cmd_valid = 1'b0;
  endtask

  task automatic send_bytes(input int n, input int base);
    int b;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      s_valid = 1'b1;
      s_data  = 8'(base + i);
      b = 0;
      while (!s_ready && b < 50) begin
        @(negedge clk);
        b++;
      end
      if (!s_ready) begin
        fail("s_ready_timeout", i);
        break;
      end
      @(posedge clk);
    end
    #1 s_valid = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int b;
    b = 0;
    do begin
      @(negedge clk);
      b++;
    end while (busy && b < 200);
    chk({name, "_idle"}, {31'h0, busy}, 32'h0);
    chk({name, "_acc_drained"}, exp_acc_q.size(), 32'h0);
    chk({name, "_rsp_drained"}, exp_rsp_q.size(), 32'h0);
  endtask

  initial begin
    int rsp0, rd0, wr0, cyc, nr;
    cmd_valid = 0; cmd_op = 0; cmd_sel = 0; cmd_idx = 0; cmd_len = 0; cmd_mask = 0;
    s_valid = 0; s_data = 0; cmd_valid2 = 0;
    repeat (3) @(negedge clk);
    chk("rst_cmd_ready", {31'h0, cmd_ready}, 32'h0);
    chk("rst_ena", {31'h0, ena}, 32'h0);
    chk("rst_addra", {16'h0, addra}, 32'h0);
    chk("rst_busy", {31'h0, busy}, 32'h0);
    chk("rst_rsp_valid", {31'h0, rsp_valid}, 32'h0);
    rst = 1'b0;
    @(negedge clk);
    chk("idle_cmd_ready", {31'h0, cmd_ready}, 32'h1);

    // 240-byte image block
    rsp0 = n_rsp;
    model_write(SEL_IMAGE, 12'd0, 240, 0);
    issue(OP_WRITE_BLK, SEL_IMAGE, 12'd0, 240, 32'h0);
    send_bytes(240, 0);
    wait_idle("blk240");
    chk("blk240_writes", wr_in_cmd, 32'd60);
    chk("blk240_first_addr", {16'h0, first_wa}, 32'h6000);
    chk("blk240_last_addr", {16'h0, last_wa}, 32'h603B);
    chk("blk240_first_data", first_wd, 32'h03020100);
    chk("blk240_last_data", last_wd, 32'hEFEEEDEC);
    chk("blk240_rsp_count", n_rsp - rsp0, 32'd1);

    // 9-byte block with padded tail
    model_write(SEL_CONV1, 12'd0, 9, 1);
    issue(OP_WRITE_BLK, SEL_CONV1, 12'd0, 9, 32'h0);
    send_bytes(9, 1);
    wait_idle("blk9");
    chk("blk9_writes", wr_in_cmd, 32'd3);
    chk("blk9_last_addr", {16'h0, last_wa}, 32'h1002);
    chk("blk9_last_data", last_wd, 32'h00000009);

    // Zero-length block
    wr0 = n_wr;
    model_write(SEL_CONV1, 12'd0, 0, 0);
    issue(OP_WRITE_BLK, SEL_CONV1, 12'd0, 0, 32'h0);
    @(negedge clk);
    chk("len0_rsp_next_cycle", {31'h0, rsp_valid}, 32'h1);
    wait_idle("len0");
    chk("len0_no_write", n_wr - wr0, 32'd0);

    // Control pulse
    exp_acc_q.push_back('{wea: 1'b1, addr: 16'h5002, data: 32'h1});
    exp_rsp_q.push_back({1'b0, 32'h0});
    issue(OP_CTRL, SEL_CTRL, CTRL_IDX_START, 0, 32'h0);
    @(negedge clk);
    chk("ctrl_ena", {31'h0, ena}, 32'h1);
    chk("ctrl_wea", {31'h0, wea}, 32'h1);
    chk("ctrl_addra", {16'h0, addra}, 32'h5002);
    chk("ctrl_dina", dina, 32'h1);
    chk("ctrl_ready_low", {31'h0, cmd_ready}, 32'h0);
    @(negedge clk);
    chk("ctrl_rsp", {31'h0, rsp_valid}, 32'h1);
    chk("ctrl_ready_low_resp", {31'h0, cmd_ready}, 32'h0);
    @(negedge clk);
    chk("ctrl_ready_back", {31'h0, cmd_ready}, 32'h1);
    wait_idle("ctrl");

    // Single read, READ_LAT=1
    rd0 = n_rd;
    rd_q.push_back(32'hFFFFF3A1);
    model_poll(SEL_STATUS, RESULT_IDX, 32'h0, 1'b1, nr);
    issue(OP_READ, SEL_STATUS, RESULT_IDX, 0, 32'h0);
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (!rsp_valid && cyc < 20);
    chk("read_lat1_cycles", cyc, 32'd3);
    chk("read_lat1_data", rsp_data, 32'hFFFFF3A1);
    wait_idle("read1");
    chk("read_lat1_pulses", n_rd - rd0, 32'd1);

    // Single read on the READ_LAT=2 instance
    @(negedge clk);
    cmd_valid2 = 1'b1;
    @(posedge clk);
    #1 cmd_valid2 = 1'b0;
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (!rsp_valid2 && cyc < 20);
    chk("read_lat2_cycles", cyc, 32'd4);
    chk("read_lat2_data", rsp_data2, 32'hFFFFF3A1);
    chk("read_lat2_err", {31'h0, rsp_err2}, 32'h0);
    repeat (2) @(negedge clk);
    chk("read_lat2_pulses", n_rd2, 32'd1);
    chk("read_lat2_idle", {31'h0, busy2}, 32'h0);

    // Poll: done appears on the 5th read
    rd0 = n_rd;
    for (int i = 0; i < 4; i++) rd_q.push_back(32'h00000002);
    rd_q.push_back(32'h00000003);
    model_poll(SEL_STATUS, STATUS_IDX, 32'h1, 1'b0, nr);
    chk("poll5_model_reads", nr, 32'd5);
    issue(OP_POLL, SEL_STATUS, STATUS_IDX, 0, 32'h1);
    wait_idle("poll5");
    chk("poll5_reads", n_rd - rd0, 32'd5);
    chk("poll5_done_bit", {31'h0, last_rsp_data[STATUS_DONE_BIT]}, 32'h1);
    chk("poll5_err", {31'h0, last_rsp_err}, 32'h0);

    // Poll: never done -> timeout
    rd0 = n_rd;
    for (int i = 0; i < TO; i++) rd_q.push_back(32'h100 + 32'(2 * i));
    model_poll(SEL_STATUS, STATUS_IDX, 32'h1, 1'b0, nr);
    chk("poll_to_model_reads", nr, 32'd8);
    issue(OP_POLL, SEL_STATUS, STATUS_IDX, 0, 32'h1);
    wait_idle("poll_to");
    chk("poll_to_reads", n_rd - rd0, 32'd8);
    chk("poll_to_err", {31'h0, last_rsp_err}, 32'h1);
    chk("poll_to_data", last_rsp_data, 32'h0000010E);

    // Poll with empty mask: first read wins
    rd0 = n_rd;
    rd_q.push_back(32'h0);
    model_poll(SEL_STATUS, STATUS_IDX, 32'h0, 1'b0, nr);
    issue(OP_POLL, SEL_STATUS, STATUS_IDX, 0, 32'h0);
    wait_idle("poll_m0");
    chk("poll_m0_reads", n_rd - rd0, 32'd1);

    // Reset after two writes of a wrapping block
    model_write(SEL_CONV2, 12'd4095, 16, 8'h40);
    void'(exp_acc_q.pop_back());
    void'(exp_acc_q.pop_back());
    void'(exp_rsp_q.pop_back());
    issue(OP_WRITE_BLK, SEL_CONV2, 12'd4095, 16, 32'h0);
    send_bytes(8, 8'h40);
    @(negedge clk);
    @(negedge clk);
    chk("abort_two_writes", wr_in_cmd, 32'd2);
    chk("abort_wrap_addr", {16'h0, last_wa}, 32'h2000);
    rst = 1'b1;
    #1;
    chk("abort_ena", {31'h0, ena}, 32'h0);
    chk("abort_wea", {31'h0, wea}, 32'h0);
    chk("abort_addra", {16'h0, addra}, 32'h0);
    chk("abort_dina", dina, 32'h0);
    chk("abort_busy", {31'h0, busy}, 32'h0);
    chk("abort_cmd_ready", {31'h0, cmd_ready}, 32'h0);
    chk("abort_s_ready", {31'h0, s_ready}, 32'h0);
    chk("abort_rsp_valid", {31'h0, rsp_valid}, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    wr0 = n_wr;
    rsp0 = n_rsp;
    s_valid = 1'b1;
    s_data  = 8'hAA;
    repeat (20) @(negedge clk);
    chk("abort_no_ena", n_wr - wr0, 32'd0);
    chk("abort_no_rsp", n_rsp - rsp0, 32'd0);
    chk("abort_s_ready_idle", {31'h0, s_ready}, 32'h0);
    s_valid = 1'b0;
    chk("abort_acc_drained", exp_acc_q.size(), 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1_000_000;
    fail("watchdog", 32'h0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/npu_host_master.md
Name: npu_host_master

Overview:
- Host-side initiator for the NPU's 32-bit block-RAM-style host port (ena/wea/addra/dina/douta).
- Accepts high-level commands from the system controller: load a byte block, pulse a control register, read a word, poll status.
- Packs the byte stream into little-endian 32-bit writes and issues them.
- Performs reads with a fixed read latency and returns a response per command; poll timeout is reported as an error.

Parameters:
- READ_LAT, 1, cycles from read issue (ena=1, wea=0) to douta valid.
- POLL_TIMEOUT, 4096, maximum POLL read attempts before error.
- LEN_W, 12, width of the byte-count field.

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- cmd_valid  in  1  command offered
- cmd_ready  out  1  command accepted when valid&ready
- cmd_op  in  2  0=WRITE_BLK, 1=CTRL, 2=READ, 3=POLL
- cmd_sel  in  3  target region, drives addra[14:12]
- cmd_idx  in  12  start word index, drives addra[11:0]
- cmd_len  in  LEN_W  WRITE_BLK byte count
- cmd_mask  in  32  POLL: status bits that must all be 1
- s_valid  in  1  payload byte valid
- s_ready  out  1  payload byte accepted
- s_data  in  8  payload byte
- ena  out  1  port enable
- wea  out  1  port write enable
- addra  out  16  {1'b0, sel, idx}
- dina  out  32  write data
- douta  in  32  read data
- rsp_valid  out  1  one-cycle completion pulse
- rsp_data  out  32  READ/POLL data; 0 otherwise
- rsp_err  out  1  qualified by rsp_valid; POLL timeout
- busy  out  1  state != IDLE

Behaviour:
- Reset: all outputs 0; state IDLE; byte counter, partial word, and timeout counter cleared. Asserting rst mid-command aborts it: no further ena and no rsp. Reset is the only abort.
- Address map:
  - sel 110 image; 001 conv1 weights; 010 conv2 weights; 011 fc1 weight stream; 100 fc2 weights; 101 control (idx 2 start, idx 3 fc1_next); 111 status.
  - Status idx 0: bit0 done, bit1 fc1_group_valid. Status idx 1: result (sign-extended 24-bit).
- cmd_ready = 1 only in IDLE. The command is registered on acceptance.
- ena/wea are single-cycle pulses. Bus fields hold their value between accesses. At most one access per cycle.
- States: IDLE, PACK, WR, CTRL, RD_ISSUE, RD_WAIT, RESP.
- WRITE_BLK:
  - cmd_len==0 goes directly to RESP: no ena, and rsp_valid pulses 1 cycle after accept.
  - Otherwise PACK. s_ready=1 while the word is incomplete. Byte k of the word goes to dina[8k+7:8k].
  - The word is complete after 4 bytes or when the last byte of the block arrives; a partial last word is zero-padded.
  - WR drives ena=wea=1 with addra={0,cmd_sel,idx} for 1 cycle, then increments idx. idx wraps 4095 to 0 with no error.
  - Returns to PACK, or to RESP after the final word.
  - Write count = ceil(len/4). Minimum per word: 4 byte cycles + 1 write cycle.
- CTRL: one write of addra={0,cmd_sel,cmd_idx}, dina=32'h1, then RESP.
- READ:
  - RD_ISSUE drives ena=1, wea=0 for 1 cycle.
  - RD_WAIT counts READ_LAT cycles, then captures douta into rsp_data and goes to RESP.
- POLL:
  - Reads as READ.
  - If (douta & cmd_mask)==cmd_mask, go to RESP with the data.
  - Otherwise increment the attempt count and reissue the read next cycle.
  - After POLL_TIMEOUT failed attempts, go to RESP with rsp_err=1 and rsp_data = last read value.
  - cmd_mask==0 succeeds on the first read.
- RESP: rsp_valid=1 for 1 cycle, then IDLE. The next command can be accepted the following cycle.
- s_valid outside PACK: ignored, s_ready=0, and bytes are not consumed.
- Unused cmd fields are ignored per op.

Decomposition:
- Shared package npu_host_pkg:
  - op enum;
  - SEL_* region constants;
  - CTRL_IDX_START=2, CTRL_IDX_FC1_NEXT=3;
  - STATUS_IDX=0, RESULT_IDX=1;
  - status bit positions.
- One sub-module: npu_byte_packer. Byte-in/word-out packer with a last flag and zero padding. It is reusable by the DMA path.

Test Plan:
- Reset mid-WRITE_BLK: rst asserted after 2 writes -> all outputs 0 immediately; after release, no ena and no rsp.
- WRITE_BLK sel=110, idx=0, len=240, bytes 0..239 -> exactly 60 writes.
  - addra 16'h6000..16'h603B.
  - First dina 32'h03020100, last dina 32'hEFEEEDEC.
  - One rsp_valid, rsp_err=0.
- WRITE_BLK sel=001, len=9, bytes 1..9 -> 3 writes to 16'h1000..16'h1002.
  - Third write dina=32'h00000009.
  - len=0 -> no ena, rsp_valid 1 cycle after accept.
- CTRL sel=101, idx=2 -> single write addra=16'h5002, dina=1; rsp follows; cmd_ready low until IDLE.
- READ idx=1 with READ_LAT=1 vs 2, model returns 32'hFFFFF3A1 -> rsp_data=32'hFFFFF3A1 at the correct cycle; exactly 1 read pulse.
- POLL mask=1 with the done bit set on the 5th read -> 5 reads, rsp_data bit0=1.
  - With POLL_TIMEOUT=8 and done never set -> 8 reads, rsp_err=1.
